ram_write_buffer: RTL and testbench

- Store buffer between the CPU data-memory write port and the data RAM, on the CPU→RAM write path inside the SOPC.
- Absorbs CPU stores into a DEPTH-entry FIFO and drains them to RAM one per cycle, only in cycles when the single-ported RAM array is not serving a CPU read.
- Detects read-after-write hazards against pending stores and stalls the CPU until they have drained.

---
 rtl/ram_write_buffer.sv | 101 ++++++++++
 tb/tb_ram_write_buffer.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/ram_write_buffer.sv
// rtl/ram_write_buffer.sv - CPU store buffer draining to a single-ported data RAM
// Stores queue in a FIFO and drain on cycles the RAM is not serving a read; RAW hits stall the CPU.
module ram_write_buffer #(
  parameter int DEPTH       = 4,
  parameter int COUNT_WIDTH = 3
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   cpu_write_enable,
  input  logic [31:0]            cpu_write_address,
  input  logic [31:0]            cpu_write_data,
  input  logic [3:0]             cpu_write_select,
  input  logic                   cpu_read_enable,
  input  logic [31:0]            cpu_read_address,
  output logic                   stall_request,
  output logic                   ram_write_enable,
  output logic [31:0]            ram_write_address,
  output logic [31:0]            ram_write_data,
  output logic [3:0]             ram_write_select,
  output logic                   buffer_empty,
  output logic [COUNT_WIDTH-1:0] buffer_count
);

  localparam int PTR_W = COUNT_WIDTH - 1;

  logic [31:0]            addr_q [DEPTH];
  logic [31:0]            data_q [DEPTH];
  logic [3:0]             sel_q  [DEPTH];
  logic [PTR_W-1:0]       head_q, head_d;
  logic [PTR_W-1:0]       tail_q, tail_d;
  logic [COUNT_WIDTH-1:0] count_q, count_d;

  logic full, empty, hazard, pop, accept;
  logic unused_read_lsbs;

  assign unused_read_lsbs = ^cpu_read_address[1:0];

  assign full  = (count_q == COUNT_WIDTH'(DEPTH));
  assign empty = (count_q == '0);

  // A slot is live when its distance from head (mod DEPTH) is below count.
  always_comb begin
    logic [PTR_W-1:0] offset;
    hazard = 1'b0;
    offset = '0;
    for (int i = 0; i < DEPTH; i++) begin
      offset = PTR_W'(i) - head_q;
      if (cpu_read_enable && (COUNT_WIDTH'(offset) < count_q) &&
          (addr_q[i][31:2] == cpu_read_address[31:2])) begin
        hazard = 1'b1;
      end
    end
  end

  // A hazard must win over the read, or the stalled load could never complete.
  assign pop           = !empty && (!cpu_read_enable || hazard);
  assign stall_request = hazard || (cpu_write_enable && full && !pop);
  assign accept        = cpu_write_enable && !stall_request && (cpu_write_select != 4'b0000);

  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q + COUNT_WIDTH'(accept) - COUNT_WIDTH'(pop);
    if (pop) begin
      head_d = head_q + PTR_W'(1);
    end
    if (accept) begin
      tail_d = tail_q + PTR_W'(1);
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        addr_q[i] <= '0;
        data_q[i] <= '0;
        sel_q[i]  <= '0;
      end
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      if (accept) begin
        addr_q[tail_q] <= cpu_write_address;
        data_q[tail_q] <= cpu_write_data;
        sel_q[tail_q]  <= cpu_write_select;
      end
    end
  end

  assign ram_write_enable  = pop;
  assign ram_write_address = addr_q[head_q];
  assign ram_write_data    = data_q[head_q];
  assign ram_write_select  = sel_q[head_q];
  assign buffer_empty      = empty;
  assign buffer_count      = count_q;

endmodule

// File: tb/tb_ram_write_buffer.sv
// tb/tb_ram_write_buffer.sv - bench for ram_write_buffer against a queue-based store model
module tb_ram_write_buffer;

  localparam int DEPTH = 4;
  localparam int CW    = 3;

  logic          clock;
  logic          reset;
  logic          cpu_write_enable;
  logic [31:0]   cpu_write_address;
  logic [31:0]   cpu_write_data;
  logic [3:0]    cpu_write_select;
  logic          cpu_read_enable;
  logic [31:0]   cpu_read_address;
  logic          stall_request;
  logic          ram_write_enable;
  logic [31:0]   ram_write_address;
  logic [31:0]   ram_write_data;
  logic [3:0]    ram_write_select;
  logic          buffer_empty;
  logic [CW-1:0] buffer_count;

  int tests  = 0;
  int failed = 0;

  typedef struct {
    logic [31:0] a;
    logic [31:0] d;
    logic [3:0]  s;
  } ent_t;
  ent_t q[$];

  ram_write_buffer #(.DEPTH(DEPTH), .COUNT_WIDTH(CW)) dut (
    .clock(clock),
    .reset(reset),
    .cpu_write_enable(cpu_write_enable),
    .cpu_write_address(cpu_write_address),
    .cpu_write_data(cpu_write_data),
    .cpu_write_select(cpu_write_select),
    .cpu_read_enable(cpu_read_enable),
    .cpu_read_address(cpu_read_address),
    .stall_request(stall_request),
    .ram_write_enable(ram_write_enable),
    .ram_write_address(ram_write_address),
    .ram_write_data(ram_write_data),
    .ram_write_select(ram_write_select),
    .buffer_empty(buffer_empty),
    .buffer_count(buffer_count)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_stall"}, 32'(stall_request), 32'd0);
    check({tag, "_ram_we"}, 32'(ram_write_enable), 32'd0);
    check({tag, "_addr"}, ram_write_address, 32'd0);
    check({tag, "_data"}, ram_write_data, 32'd0);
    check({tag, "_sel"}, 32'(ram_write_select), 32'd0);
    check({tag, "_empty"}, 32'(buffer_empty), 32'd1);
    check({tag, "_count"}, 32'(buffer_count), 32'd0);
  endtask

  // Called at posedge+1: drive, check the model's view of this cycle, then advance the model.
  task automatic cycle(input logic we, input logic [31:0] wa, input logic [31:0] wd,
                       input logic [3:0] ws, input logic re, input logic [31:0] ra);
    logic hz, pp, st, ac;
    cpu_write_enable  = we;
    cpu_write_address = wa;
    cpu_write_data    = wd;
    cpu_write_select  = ws;
    cpu_read_enable   = re;
    cpu_read_address  = ra;
    #1;
    hz = 1'b0;
    foreach (q[i]) if (re && (q[i].a[31:2] == ra[31:2])) hz = 1'b1;
    pp = (q.size() != 0) && (!re || hz);
    st = hz || (we && (q.size() == DEPTH) && !pp);
    ac = we && !st && (ws != 4'b0000);
    check("stall", 32'(stall_request), 32'(st));
    check("ram_we", 32'(ram_write_enable), 32'(pp));
    check("empty", 32'(buffer_empty), 32'(q.size() == 0));
    check("count", 32'(buffer_count), 32'(q.size()));
    if (q.size() != 0) begin
      check("head_addr", ram_write_address, q[0].a);
      check("head_data", ram_write_data, q[0].d);
      check("head_sel", 32'(ram_write_select), 32'(q[0].s));
    end
    @(posedge clock);
    if (pp) void'(q.pop_front());
    if (ac) q.push_back('{wa, wd, ws});
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, 32'h0, 32'h0, 4'h0, 1'b0, 32'h0);
  endtask

  initial begin
    logic [31:0] wa, ra, wd;
    logic [3:0]  ws;
    logic        we, re;

    reset = 1'b1;
    cpu_write_enable = 1'b0; cpu_write_address = '0; cpu_write_data = '0;
    cpu_write_select = '0;   cpu_read_enable = 1'b0; cpu_read_address = '0;
    #2 reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clock); #1;
      check_reset_outputs("reset");
    end
    reset = 1'b1;
    idle(3);

    // Single store drains the following cycle
    cycle(1'b1, 32'h100, 32'hDEADBEEF, 4'hF, 1'b0, 32'h0);
    check("single_ram_we", 32'(ram_write_enable), 32'd1);
    check("single_addr", ram_write_address, 32'h100);
    check("single_data", ram_write_data, 32'hDEADBEEF);
    idle(2);

    // Fill while reads hold the array; fifth store stalls until the read drops
    for (int i = 0; i < 4; i++) cycle(1'b1, 32'(i * 4), $urandom, 4'hF, 1'b1, 32'h800);
    cycle(1'b1, 32'h10, 32'h5555AAAA, 4'hF, 1'b1, 32'h800);
    cycle(1'b1, 32'h10, 32'h5555AAAA, 4'hF, 1'b1, 32'h800);
    cycle(1'b1, 32'h10, 32'h5555AAAA, 4'hF, 1'b0, 32'h0);
    check("fill_count_after", 32'(buffer_count), 32'd4);
    idle(6);

    // RAW hazard on the same word, then a neighbouring word with no hazard
    cycle(1'b1, 32'h104, 32'h000000A5, 4'b0001, 1'b0, 32'h0);
    cycle(1'b0, 32'h0, 32'h0, 4'h0, 1'b1, 32'h107);
    cycle(1'b0, 32'h0, 32'h0, 4'h0, 1'b1, 32'h107);
    cycle(1'b1, 32'h104, 32'h000000A5, 4'b0001, 1'b0, 32'h0);
    cycle(1'b0, 32'h0, 32'h0, 4'h0, 1'b1, 32'h108);
    cycle(1'b0, 32'h0, 32'h0, 4'h0, 1'b1, 32'h108);
    idle(2);

    // Full with simultaneous pop, repeated to wrap the pointers; zero-select store is a no-op
    for (int i = 0; i < 4; i++) cycle(1'b1, 32'h300 + 32'(i * 4), $urandom, 4'hF, 1'b1, 32'h900);
    for (int i = 0; i < 5; i++) cycle(1'b1, 32'h400 + 32'(i * 4), $urandom, 4'(i + 3), 1'b0, 32'h0);
    cycle(1'b1, 32'h500, 32'h12345678, 4'h0, 1'b1, 32'h900);
    idle(6);

    // Asynchronous reset between edges discards pending stores
    for (int i = 0; i < 3; i++) cycle(1'b1, 32'h600 + 32'(i * 4), $urandom, 4'hF, 1'b1, 32'hA00);
    cpu_write_enable = 1'b0; cpu_read_enable = 1'b0;
    cpu_write_select = 4'h0; cpu_write_address = '0; cpu_read_address = '0;
    reset = 1'b0;
    #1;
    check_reset_outputs("async_reset");
    q.delete();
    @(posedge clock); #1;
    reset = 1'b1;
    idle(4);

    // Randomized traffic over a small address window so hazards are frequent
    for (int n = 0; n < 400; n++) begin
      we = 1'($urandom_range(0, 1));
      re = ($urandom_range(0, 2) == 0);
      wa = 32'h200 + (32'($urandom_range(0, 7)) << 2) + 32'($urandom_range(0, 3));
      ra = 32'h200 + (32'($urandom_range(0, 9)) << 2) + 32'($urandom_range(0, 3));
      wd = $urandom;
      ws = 4'($urandom_range(0, 15));
      cycle(we, wa, wd, ws, re, ra);
    end
    idle(6);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
